regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback result, either load data or ALU result.
- Commits the result into the 32x32 architectural register file.
- Serves the two combinational decode-stage read ports, with same-cycle write-to-read bypass.
- Sits between the MEM/WB register (write side) and the decode stage / ID-EX register (read side).

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register index width
- DEPTH, 32, number of architectural registers; must equal 2**ADDR_W

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- RegwriteW  input  1  writeback enable from MEM/WB register
- MemtoregW  input  1  1 = write ReaddataW, 0 = write ALUoutW
- ReaddataW  input  DATA_W  load data from MEM/WB register
- ALUoutW  input  DATA_W  ALU result from MEM/WB register
- WriteregW  input  ADDR_W  destination register index
- RsD  input  ADDR_W  read port 1 index (decode stage)
- RtD  input  ADDR_W  read port 2 index (decode stage)
- RD1D  output  DATA_W  read port 1 data, combinational
- RD2D  output  DATA_W  read port 2 data, combinational
- ResultW  output  DATA_W  selected writeback value, for forwarding to E stage

Behaviour:
- Reset is fixed: one clock (clk), asynchronous active-low reset (rst_n).
  - While rst_n=0: all DEPTH registers clear to 0 immediately, without waiting for clk.
  - While rst_n=0: RD1D, RD2D and trace outputs read 0; bypass is suppressed.
  - ResultW stays combinational from its inputs during reset.
- Result select (combinational): ResultW = MemtoregW ? ReaddataW : ALUoutW.
- Commit: we = RegwriteW & (WriteregW != 0) & rst_n.
  - On the rising clk edge with we=1: reg[WriteregW] <= ResultW.
  - One write per cycle; write latency 1 edge.
- Register 0 is hardwired zero.
  - Writes to index 0 are discarded and never increment trace state.
  - Reads of index 0 return 0 regardless of bypass.
- Read ports (combinational, zero latency):
  - RD1D = (RsD==0) ? 0 : (we & RsD==WriteregW) ? ResultW : reg[RsD].
  - RD2D follows the same rule with RtD.
  - The bypass makes a write and a read of the same register in the same cycle return the new value (write-through). No hazard stall is required for the W-to-D distance.
- Both ports reading the same index return identical data, including under bypass.
- RegwriteW=0: no state change; MemtoregW, ReaddataW and ALUoutW are don't-care for state but still drive ResultW.
- Reset asserted mid-write (rst_n falls before the edge): the write is lost and the register stays 0.
- Reset deasserted: the first commit occurs at the first rising edge where we=1.
- No X propagation: out-of-range indices cannot occur, since DEPTH=2**ADDR_W.

Optional Feature:
- Macro: REGFILE_WB_TRACE_EN.
- Defined: adds outputs WbCountW (32), LastWriteregW (ADDR_W) and LastDataW (DATA_W), all reset to 0.
  - On each commit (we=1): WbCountW increments by 1, wrapping 0xFFFFFFFF -> 0x00000000.
  - On each commit: LastWriteregW <= WriteregW and LastDataW <= ResultW, all updated on the same edge as the register write.
  - Used by the test bench and on-board debug for retirement tracking.
- Undefined: these ports and their flops do not exist; all other behaviour is identical.

Test Plan:
- Reset then read: rst_n=0 asynchronously mid-cycle, RsD=5, RtD=31 -> RD1D=RD2D=0 immediately; after release, still 0 before any write.
- ALU writeback: RegwriteW=1, MemtoregW=0, ALUoutW=0x0000_1234, WriteregW=8, one edge; then RsD=8 -> RD1D=0x0000_1234; ResultW=0x1234 during the write cycle.
- Load writeback with bypass: RegwriteW=1, MemtoregW=1, ReaddataW=0xDEAD_BEEF, WriteregW=9, RsD=RtD=9 in the same cycle -> RD1D=RD2D=0xDEAD_BEEF before the edge; reg9 holds it after the edge.
- r0 protection: RegwriteW=1, WriteregW=0, ALUoutW=0xFFFF_FFFF, RsD=0 -> RD1D=0 before and after the edge; with REGFILE_WB_TRACE_EN, WbCountW unchanged.
- Disabled write: RegwriteW=0, WriteregW=8, ALUoutW=0x5555_5555 -> reg8 keeps 0x0000_1234; no bypass on RsD=8.
- Trace wrap (REGFILE_WB_TRACE_EN): force WbCountW to 0xFFFF_FFFF, commit to reg3 with 0x77 -> WbCountW=0, LastWriteregW=3, LastDataW=0x77; rst_n pulse -> all three read 0.

Source files
------------

// File: rtl/regfile_wb.sv
// Writeback stage: selects the result, commits it to the 32x32 register file and
// serves two bypassed read ports. Define REGFILE_WB_TRACE_EN to add retirement trace outputs.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegwriteW,
  input  logic              MemtoregW,
  input  logic [DATA_W-1:0] ReaddataW,
  input  logic [DATA_W-1:0] ALUoutW,
  input  logic [ADDR_W-1:0] WriteregW,
  input  logic [ADDR_W-1:0] RsD,
  input  logic [ADDR_W-1:0] RtD,
`ifdef REGFILE_WB_TRACE_EN
  output logic [31:0]       WbCountW,
  output logic [ADDR_W-1:0] LastWriteregW,
  output logic [DATA_W-1:0] LastDataW,
`endif
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] ResultW
);

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs [DEPTH];
  logic              we;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // rst_n gates the enable so a write racing a falling reset is dropped
  assign we      = RegwriteW & (WriteregW != ZERO_ADDR) & rst_n;
  assign ResultW = MemtoregW ? ReaddataW : ALUoutW;

  // Register file storage; entry 0 is never written so it stays at its reset zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= ZERO_DATA;
      end
    end else if (we) begin
      regs[WriteregW] <= ResultW;
    end else begin
      regs[WriteregW] <= regs[WriteregW];
    end
  end

  // Read port 1 with write-through bypass
  always_comb begin
    rd1 = ZERO_DATA;
    if (!rst_n || (RsD == ZERO_ADDR)) begin
      rd1 = ZERO_DATA;
    end else if (we && (RsD == WriteregW)) begin
      rd1 = ResultW;
    end else begin
      rd1 = regs[RsD];
    end
  end

  // Read port 2 with write-through bypass
  always_comb begin
    rd2 = ZERO_DATA;
    if (!rst_n || (RtD == ZERO_ADDR)) begin
      rd2 = ZERO_DATA;
    end else if (we && (RtD == WriteregW)) begin
      rd2 = ResultW;
    end else begin
      rd2 = regs[RtD];
    end
  end

  assign RD1D = rd1;
  assign RD2D = rd2;

`ifdef REGFILE_WB_TRACE_EN
  logic [31:0]       wbCount;
  logic [ADDR_W-1:0] lastWritereg;
  logic [DATA_W-1:0] lastData;

  // Retirement trace, updated on the same edge as the commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbCount      <= 32'd0;
      lastWritereg <= ZERO_ADDR;
      lastData     <= ZERO_DATA;
    end else if (we) begin
      wbCount      <= wbCount + 32'd1;
      lastWritereg <= WriteregW;
      lastData     <= ResultW;
    end else begin
      wbCount      <= wbCount;
      lastWritereg <= lastWritereg;
      lastData     <= lastData;
    end
  end

  assign WbCountW      = wbCount;
  assign LastWriteregW = lastWritereg;
  assign LastDataW     = lastData;
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb; inputs change on the falling edge,
// outputs are checked between edges.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegwriteW;
  logic        MemtoregW;
  logic [31:0] ReaddataW;
  logic [31:0] ALUoutW;
  logic [4:0]  WriteregW;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;
`ifdef REGFILE_WB_TRACE_EN
  logic [31:0] WbCountW;
  logic [4:0]  LastWriteregW;
  logic [31:0] LastDataW;
`endif

  int nCmp = 0;
  int nErr = 0;

  regfile_wb dut (
    .clk(clk),
    .rst_n(rst_n),
    .RegwriteW(RegwriteW),
    .MemtoregW(MemtoregW),
    .ReaddataW(ReaddataW),
    .ALUoutW(ALUoutW),
    .WriteregW(WriteregW),
    .RsD(RsD),
    .RtD(RtD),
`ifdef REGFILE_WB_TRACE_EN
    .WbCountW(WbCountW),
    .LastWriteregW(LastWriteregW),
    .LastDataW(LastDataW),
`endif
    .RD1D(RD1D),
    .RD2D(RD2D),
    .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; RegwriteW = 1'b0; MemtoregW = 1'b0;
    ReaddataW = 32'd0; ALUoutW = 32'd0; WriteregW = 5'd0; RsD = 5'd0; RtD = 5'd0;
    #1;
    chk("init_rd1", RD1D, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Preload reg5 so the asynchronous clear is observable
    RegwriteW = 1'b1; WriteregW = 5'd5; ALUoutW = 32'hAAAA_0005; RsD = 5'd5; RtD = 5'd31;
    #1;
    chk("pre_bypass5", RD1D, 32'hAAAA_0005);
    @(negedge clk);
    RegwriteW = 1'b0;
    #1;
    chk("pre_reg5", RD1D, 32'hAAAA_0005);

    // Asynchronous reset mid-cycle with a pending write to reg5
    #2;
    RegwriteW = 1'b1; WriteregW = 5'd5; ALUoutW = 32'h0000_1111;
    rst_n = 1'b0;
    #1;
    chk("rst_rd1", RD1D, 32'd0);
    chk("rst_rd2", RD2D, 32'd0);
    chk("rst_result", ResultW, 32'h0000_1111);
    @(negedge clk);
    RegwriteW = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd1", RD1D, 32'd0);
    chk("post_rst_rd2", RD2D, 32'd0);
`ifdef REGFILE_WB_TRACE_EN
    chk("post_rst_cnt", WbCountW, 32'd0);
`endif

    // ALU writeback to reg8
    @(negedge clk);
    RegwriteW = 1'b1; MemtoregW = 1'b0; ALUoutW = 32'h0000_1234; ReaddataW = 32'h0BAD_0BAD;
    WriteregW = 5'd8; RsD = 5'd0; RtD = 5'd0;
    #1;
    chk("alu_result", ResultW, 32'h0000_1234);
    @(negedge clk);
    RegwriteW = 1'b0; RsD = 5'd8;
    #1;
    chk("alu_reg8", RD1D, 32'h0000_1234);
`ifdef REGFILE_WB_TRACE_EN
    chk("alu_cnt", WbCountW, 32'd1);
`endif

    // Load writeback to reg9, both ports bypassed
    RegwriteW = 1'b1; MemtoregW = 1'b1; ReaddataW = 32'hDEAD_BEEF; ALUoutW = 32'h0BAD_0BAD;
    WriteregW = 5'd9; RsD = 5'd9; RtD = 5'd9;
    #1;
    chk("ld_result", ResultW, 32'hDEAD_BEEF);
    chk("ld_byp_rd1", RD1D, 32'hDEAD_BEEF);
    chk("ld_byp_rd2", RD2D, 32'hDEAD_BEEF);
    @(negedge clk);
    RegwriteW = 1'b0; MemtoregW = 1'b0;
    #1;
    chk("ld_reg9_rd1", RD1D, 32'hDEAD_BEEF);
    chk("ld_reg9_rd2", RD2D, 32'hDEAD_BEEF);
`ifdef REGFILE_WB_TRACE_EN
    chk("ld_cnt", WbCountW, 32'd2);
    chk("ld_lastreg", {27'd0, LastWriteregW}, 32'd9);
    chk("ld_lastdata", LastDataW, 32'hDEAD_BEEF);
`endif

    // Write to r0 is discarded
    RegwriteW = 1'b1; WriteregW = 5'd0; ALUoutW = 32'hFFFF_FFFF; RsD = 5'd0; RtD = 5'd8;
    #1;
    chk("r0_before", RD1D, 32'd0);
    chk("r0_rd2_reg8", RD2D, 32'h0000_1234);
    @(negedge clk);
    RegwriteW = 1'b0;
    #1;
    chk("r0_after", RD1D, 32'd0);
`ifdef REGFILE_WB_TRACE_EN
    chk("r0_cnt", WbCountW, 32'd2);
`endif

    // Disabled write: no state change, no bypass
    RegwriteW = 1'b0; WriteregW = 5'd8; ALUoutW = 32'h5555_5555; RsD = 5'd8; RtD = 5'd9;
    #1;
    chk("dis_result", ResultW, 32'h5555_5555);
    chk("dis_nobyp", RD1D, 32'h0000_1234);
    @(negedge clk);
    #1;
    chk("dis_reg8", RD1D, 32'h0000_1234);
    chk("dis_reg9", RD2D, 32'hDEAD_BEEF);

    // Highest index, bypass on port 2 only
    RegwriteW = 1'b1; WriteregW = 5'd31; ALUoutW = 32'h8000_0001; RsD = 5'd8; RtD = 5'd31;
    #1;
    chk("r31_byp_rd2", RD2D, 32'h8000_0001);
    chk("r31_rd1_reg8", RD1D, 32'h0000_1234);
    @(negedge clk);
    RegwriteW = 1'b0; RsD = 5'd31; RtD = 5'd5;
    #1;
    chk("r31_reg", RD1D, 32'h8000_0001);
    chk("r5_cleared", RD2D, 32'd0);

`ifdef REGFILE_WB_TRACE_EN
    // Counter wrap, then reset clears all trace state
    force dut.wbCount = 32'hFFFF_FFFF;
    #1;
    release dut.wbCount;
    RegwriteW = 1'b1; WriteregW = 5'd3; ALUoutW = 32'h0000_0077;
    @(negedge clk);
    RegwriteW = 1'b0;
    #1;
    chk("wrap_cnt", WbCountW, 32'd0);
    chk("wrap_lastreg", {27'd0, LastWriteregW}, 32'd3);
    chk("wrap_lastdata", LastDataW, 32'h0000_0077);
    rst_n = 1'b0;
    #1;
    chk("trst_cnt", WbCountW, 32'd0);
    chk("trst_lastreg", {27'd0, LastWriteregW}, 32'd0);
    chk("trst_lastdata", LastDataW, 32'd0);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
